// File: rtl/led_pattern_gen.sv
// Multi-pattern LED driver: binary, Gray, bouncing scanner and PWM breathing,
// all advanced by one shared prescaled step tick.
module led_pattern_gen #(
   parameter int NUM_LEDS       = 8,
   parameter int PRESCALE_WIDTH = 20,
   parameter int PWM_WIDTH      = 8
) (
   input  logic                CLK_IN,
   input  logic                RST_IN,
   input  logic                ENABLE_IN,
   input  logic [1:0]          MODE_IN,
   output logic [NUM_LEDS-1:0] LED_OUT,
   output logic                STEP_OUT
);

   localparam int POS_W = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

   typedef enum logic [1:0] {
      MODE_BIN    = 2'b00,
      MODE_GRAY   = 2'b01,
      MODE_SCAN   = 2'b10,
      MODE_BREATH = 2'b11
   } mode_e;

   mode_e                     mode_q, mode_d, mode_in;
   logic [PRESCALE_WIDTH-1:0] prescaler_q, prescaler_d;
   logic [NUM_LEDS-1:0]       step_cnt_q, step_cnt_d;
   logic [POS_W-1:0]          pos_q, pos_d;
   logic                      dir_down_q, dir_down_d;
   logic [PWM_WIDTH-1:0]      duty_q, duty_d;
   logic                      duty_down_q, duty_down_d;
   logic [PWM_WIDTH-1:0]      pwm_cnt_q, pwm_cnt_d;
   logic [NUM_LEDS-1:0]       led_q, led_d;
   logic                      step_q, step_d;
   logic                      tick;

   assign mode_in = mode_e'(MODE_IN);
   assign tick    = ENABLE_IN && (prescaler_q == '1);

   always_comb begin
      mode_d      = mode_q;
      prescaler_d = prescaler_q;
      step_cnt_d  = step_cnt_q;
      pos_d       = pos_q;
      dir_down_d  = dir_down_q;
      duty_d      = duty_q;
      duty_down_d = duty_down_q;
      pwm_cnt_d   = pwm_cnt_q;
      step_d      = 1'b0;
      led_d       = '0;

      // LED drive reflects the pre-edge state of the registered mode.
      case (mode_q)
         MODE_BIN:    led_d = step_cnt_q;
         MODE_GRAY:   led_d = step_cnt_q ^ (step_cnt_q >> 1);
         MODE_SCAN:   led_d[pos_q] = 1'b1;
         MODE_BREATH: led_d = {NUM_LEDS{pwm_cnt_q < duty_q}};
         default:     led_d = '0;
      endcase

      if (mode_in != mode_q) begin
         mode_d      = mode_in;
         prescaler_d = '0;
         step_cnt_d  = '0;
         pos_d       = '0;
         dir_down_d  = 1'b0;
         duty_d      = '0;
         duty_down_d = 1'b0;
         pwm_cnt_d   = '0;
      end else begin
         pwm_cnt_d = pwm_cnt_q + 1'b1;
         if (ENABLE_IN) begin
            prescaler_d = prescaler_q + 1'b1;
         end
         if (tick) begin
            step_d = 1'b1;
            case (mode_q)
               MODE_BIN, MODE_GRAY: step_cnt_d = step_cnt_q + 1'b1;
               MODE_SCAN: begin
                  // Bounce: each end position is held for a single step.
                  if (!dir_down_q) begin
                     pos_d = pos_q + 1'b1;
                     if (pos_d == POS_LAST) dir_down_d = 1'b1;
                  end else begin
                     pos_d = pos_q - 1'b1;
                     if (pos_d == '0) dir_down_d = 1'b0;
                  end
               end
               MODE_BREATH: begin
                  if (!duty_down_q) begin
                     duty_d = duty_q + 1'b1;
                     if (duty_d == '1) duty_down_d = 1'b1;
                  end else begin
                     duty_d = duty_q - 1'b1;
                     if (duty_d == '0) duty_down_d = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         mode_q      <= mode_in;
         prescaler_q <= '0;
         step_cnt_q  <= '0;
         pos_q       <= '0;
         dir_down_q  <= 1'b0;
         duty_q      <= '0;
         duty_down_q <= 1'b0;
         pwm_cnt_q   <= '0;
         led_q       <= '0;
         step_q      <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         prescaler_q <= prescaler_d;
         step_cnt_q  <= step_cnt_d;
         pos_q       <= pos_d;
         dir_down_q  <= dir_down_d;
         duty_q      <= duty_d;
         duty_down_q <= duty_down_d;
         pwm_cnt_q   <= pwm_cnt_d;
         led_q       <= led_d;
         step_q      <= step_d;
      end
   end

   assign LED_OUT  = led_q;
   assign STEP_OUT = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed pattern checks plus a
// randomized run, both compared against a tick-count based reference model.
module tb_led_pattern_gen;

   localparam int N          = 4;
   localparam int PRE_W      = 2;
   localparam int PWM_W      = 3;
   localparam int PRE_PERIOD = 1 << PRE_W;
   localparam int PWM_PERIOD = 1 << PWM_W;
   localparam int DUTY_MAX   = PWM_PERIOD - 1;

   logic         clk;
   logic         rst_in;
   logic         en_in;
   logic [1:0]   mode_in;
   logic [N-1:0] led_out;
   logic         step_out;

   int checks;
   int pass_cnt;

   // Reference model: ticks taken since the last reset or mode change.
   int m_mode, m_k, m_pre, m_pwm;
   int exp_led, exp_step;

   int gray_tbl [9];
   int scan_tbl [9];

   led_pattern_gen #(
      .NUM_LEDS(N),
      .PRESCALE_WIDTH(PRE_W),
      .PWM_WIDTH(PWM_W)
   ) dut (
      .CLK_IN(clk),
      .RST_IN(rst_in),
      .ENABLE_IN(en_in),
      .MODE_IN(mode_in),
      .LED_OUT(led_out),
      .STEP_OUT(step_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int model_duty(input int k);
      int q;
      q = k % (2 * DUTY_MAX);
      return (q <= DUTY_MAX) ? q : 2 * DUTY_MAX - q;
   endfunction

   function automatic int model_led(input int mode, input int k, input int pwm);
      int g, p;
      case (mode)
         0: return k % (1 << N);
         1: begin
            g = k % (1 << N);
            return g ^ (g >> 1);
         end
         2: begin
            p = k % (2 * (N - 1));
            if (p > N - 1) p = 2 * (N - 1) - p;
            return 1 << p;
         end
         default: return (pwm < model_duty(k)) ? (1 << N) - 1 : 0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) pass_cnt++;
      else $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] mode);
      rst_in  = rst;
      en_in   = en;
      mode_in = mode;
      @(posedge clk);
      if (rst) begin
         exp_led  = 0;
         exp_step = 0;
         m_mode   = int'(mode);
         m_k      = 0;
         m_pre    = 0;
         m_pwm    = 0;
      end else begin
         exp_led  = model_led(m_mode, m_k, m_pwm);
         exp_step = 0;
         if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_k    = 0;
            m_pre  = 0;
            m_pwm  = 0;
         end else begin
            m_pwm = (m_pwm + 1) % PWM_PERIOD;
            if (en) begin
               if (m_pre == PRE_PERIOD - 1) begin
                  m_pre    = 0;
                  m_k      = m_k + 1;
                  exp_step = 1;
               end else begin
                  m_pre = m_pre + 1;
               end
            end
         end
      end
      #1;
      checkOutput("led", 32'(led_out), 32'(exp_led));
      checkOutput("step", 32'(step_out), 32'(exp_step));
   endtask

   initial begin
      int highs, lit8, cyc;
      logic [1:0] rmode;
      checks   = 0;
      pass_cnt = 0;
      m_mode = 0; m_k = 0; m_pre = 0; m_pwm = 0; exp_led = 0; exp_step = 0;
      gray_tbl = '{0, 1, 3, 2, 6, 7, 5, 4, 12};
      scan_tbl = '{1, 2, 4, 8, 4, 2, 1, 2, 4};
      rst_in = 1'b1; en_in = 1'b1; mode_in = 2'b00;

      $display("[TB] reset");
      applyStimulus(1, 1, 2'b00);
      applyStimulus(1, 1, 2'b00);
      checkOutput("reset_led", 32'(led_out), 32'd0);

      $display("[TB] binary count and wrap");
      for (int c = 1; c <= 16; c++) begin
         applyStimulus(0, 1, 2'b00);
         checkOutput("bin_step_cycle", 32'(step_out), (c % 4 == 0) ? 32'd1 : 32'd0);
      end
      for (int c = 0; c < 70; c++) applyStimulus(0, 1, 2'b00);

      $display("[TB] enable freeze at 0101");
      cyc = 0;
      while (!(exp_step == 1 && (m_k % 16) == 5) && cyc < 200) begin
         applyStimulus(0, 1, 2'b00);
         cyc++;
      end
      checkOutput("reach_0101", 32'(cyc < 200), 32'd1);
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(0, 0, 2'b00);
         checkOutput("freeze_step", 32'(step_out), 32'd0);
         if (c > 1) checkOutput("freeze_led", 32'(led_out), 32'h5);
      end
      for (int c = 1; c <= 4; c++) begin
         applyStimulus(0, 1, 2'b00);
         checkOutput("reenable_step", 32'(step_out), (c == 4) ? 32'd1 : 32'd0);
      end
      applyStimulus(0, 1, 2'b00);
      checkOutput("reenable_led", 32'(led_out), 32'h6);

      $display("[TB] Gray sequence");
      applyStimulus(0, 1, 2'b01);
      checkOutput("gray_switch_step", 32'(step_out), 32'd0);
      for (int j = 0; j < 9; j++) begin
         for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 1, 2'b01);
            if (c == 2) checkOutput("gray_seq", 32'(led_out), 32'(gray_tbl[j]));
         end
      end

      $display("[TB] scanner sequence");
      applyStimulus(0, 1, 2'b10);
      lit8 = 0;
      for (int j = 0; j < 9; j++) begin
         for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 1, 2'b10);
            if (led_out == 4'b1000) lit8++;
            if (c == 2) checkOutput("scan_seq", 32'(led_out), 32'(scan_tbl[j]));
         end
      end
      checkOutput("scan_end_one_step", 32'(lit8), 32'd4);

      $display("[TB] breathing");
      applyStimulus(0, 1, 2'b11);
      for (int c = 0; c < 4; c++) begin
         applyStimulus(0, 1, 2'b11);
         checkOutput("breath_duty0_led", 32'(led_out), 32'd0);
      end
      cyc = 0;
      while (m_k < 3 && cyc < 100) begin
         applyStimulus(0, 1, 2'b11);
         cyc++;
      end
      checkOutput("reach_duty3", 32'(m_k), 32'd3);
      highs = 0;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(0, 0, 2'b11);
         if (led_out == 4'b1111) highs++;
      end
      checkOutput("breath_duty3_highs", 32'(highs), 32'd3);
      cyc = 0;
      while (m_k < 7 && cyc < 100) begin
         applyStimulus(0, 1, 2'b11);
         cyc++;
      end
      highs = 0;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(0, 0, 2'b11);
         if (led_out == 4'b1111) highs++;
      end
      checkOutput("breath_duty7_highs", 32'(highs), 32'd7);
      cyc = 0;
      while (m_k < 14 && cyc < 100) begin
         applyStimulus(0, 1, 2'b11);
         cyc++;
      end
      highs = 0;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(0, 0, 2'b11);
         if (led_out != 4'b0000) highs++;
      end
      checkOutput("breath_back_to_0", 32'(highs), 32'd0);

      $display("[TB] mode switch on due tick, then reset mid-scan");
      applyStimulus(0, 1, 2'b00);
      cyc = 0;
      while (m_pre != PRE_PERIOD - 1 && cyc < 10) begin
         applyStimulus(0, 1, 2'b00);
         cyc++;
      end
      checkOutput("tick_due", 32'(m_pre), 32'(PRE_PERIOD - 1));
      applyStimulus(0, 1, 2'b10);
      checkOutput("switch_no_step", 32'(step_out), 32'd0);
      for (int c = 1; c <= 4; c++) begin
         applyStimulus(0, 1, 2'b10);
         if (c == 1) checkOutput("switch_led", 32'(led_out), 32'h1);
         checkOutput("switch_next_tick", 32'(step_out), (c == 4) ? 32'd1 : 32'd0);
      end
      for (int c = 0; c < 6; c++) applyStimulus(0, 1, 2'b10);
      applyStimulus(1, 1, 2'b10);
      checkOutput("midscan_reset_led", 32'(led_out), 32'd0);
      checkOutput("midscan_reset_step", 32'(step_out), 32'd0);

      $display("[TB] randomized run");
      rmode = 2'b10;
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 39) == 0) rmode = 2'($urandom_range(0, 3));
         applyStimulus(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, rmode);
      end

      $display("%0d/%0d checks passed", pass_cnt, checks);
      $finish;
   end

endmodule
